// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 2R/1W register file: round-robin arbitration of two
// writeback requesters, optional register-0 write suppression, and a clear sweep.
module regfile_wr_arbiter #(
    parameter int BW_DATA  = 32,
    parameter int BW_ADDR  = 5,
    parameter int ZERO_REG = 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_clr,
    output logic               o_busy,
    input  logic               i_req0_valid,
    output logic               o_req0_ready,
    input  logic [BW_ADDR-1:0] i_req0_addr,
    input  logic [BW_DATA-1:0] i_req0_data,
    input  logic               i_req1_valid,
    output logic               o_req1_ready,
    input  logic [BW_ADDR-1:0] i_req1_addr,
    input  logic [BW_DATA-1:0] i_req1_data,
    output logic               o_rf_wr_en,
    output logic [BW_ADDR-1:0] o_rf_wr_addr,
    output logic [BW_DATA-1:0] o_rf_wr_data
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

    localparam logic [BW_ADDR-1:0] CNT_MAX = {BW_ADDR{1'b1}};

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [BW_ADDR-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               wr_en_q, wr_en_d;
    logic [BW_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [BW_DATA-1:0] wr_data_q, wr_data_d;
    logic               idle_s;
    logic               xfer0_s, xfer1_s;

    // Readiness never looks at the requester's own valid, so it cannot form a loop.
    assign idle_s       = (state_q == ST_IDLE) && !i_clr;
    assign o_req0_ready = idle_s && (!ptr_q || !i_req1_valid);
    assign o_req1_ready = idle_s && ( ptr_q || !i_req0_valid);
    assign xfer0_s      = o_req0_ready && i_req0_valid;
    assign xfer1_s      = o_req1_ready && i_req1_valid;

    // Next-state, pointer, sweep counter and write-port values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {BW_ADDR{1'b0}};
                    busy_d  = 1'b1;
                end else if (xfer0_s) begin
                    ptr_d     = 1'b1;
                    wr_addr_d = i_req0_addr;
                    wr_data_d = i_req0_data;
                    wr_en_d   = !((ZERO_REG != 0) && (i_req0_addr == {BW_ADDR{1'b0}}));
                end else if (xfer1_s) begin
                    ptr_d     = 1'b0;
                    wr_addr_d = i_req1_addr;
                    wr_data_d = i_req1_data;
                    wr_en_d   = !((ZERO_REG != 0) && (i_req1_addr == {BW_ADDR{1'b0}}));
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                // The sweep writes address 0 too, regardless of ZERO_REG.
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = {BW_DATA{1'b0}};
                cnt_d     = cnt_q + BW_ADDR'(1);
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            cnt_q     <= {BW_ADDR{1'b0}};
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {BW_ADDR{1'b0}};
            wr_data_q <= {BW_DATA{1'b0}};
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_rf_wr_en   = wr_en_q;
    assign o_rf_wr_addr = wr_addr_q;
    assign o_rf_wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed expected writes, a negedge
// monitor pops and compares every register-file write strobe.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clr = 1'b0;
    logic        busy;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic        rdy0, rdy1;
    logic [4:0]  a0 = 5'd0, a1 = 5'd0;
    logic [31:0] d0 = 32'd0, d1 = 32'd0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    regfile_wr_arbiter #(.BW_DATA(32), .BW_ADDR(5), .ZERO_REG(1)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .o_busy(busy),
        .i_req0_valid(v0), .o_req0_ready(rdy0), .i_req0_addr(a0), .i_req0_data(d0),
        .i_req1_valid(v1), .o_req1_ready(rdy1), .i_req1_addr(a1), .i_req1_data(d1),
        .o_rf_wr_en(wr_en), .o_rf_wr_addr(wr_addr), .o_rf_wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rstn && wr_en) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, none expected", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    fails++;
                    $display("FAIL write: got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             wr_addr, wr_data, e.a, e.d);
                end
            end
        end
    end

    logic [4:0]  ct_addr [4] = '{5'd1, 5'd9, 5'd2, 5'd10};
    logic [31:0] ct_data [4] = '{32'h101, 32'h209, 32'h102, 32'h20A};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_addr", {27'd0, wr_addr}, 32'd0);
        chk("rst_data", wr_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        next_cycle();

        // Single write from requester 0
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hDEADBEEF;
        @(negedge clk);
        chk("single_rdy0", {31'd0, rdy0}, 32'd1);
        push(5'd5, 32'hDEADBEEF);
        next_cycle();
        v0 = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        chk("single_wr_en_drop", {31'd0, wr_en}, 32'd0);
        next_cycle();

        // Requester 1 alone returns the pointer to requester 0
        v1 = 1'b1; a1 = 5'd7; d1 = 32'h77;
        @(negedge clk);
        chk("r1_alone_rdy1", {31'd0, rdy1}, 32'd1);
        push(5'd7, 32'h77);
        next_cycle();
        v1 = 1'b0;

        // Contention: grants alternate 0,1,0,1 with stalled side holding its request
        begin
            int i0 = 0, i1 = 0;
            for (int i = 0; i < 4; i++) begin
                v0 = 1'b1; a0 = 5'(1 + i0); d0 = 32'h100 | 32'(1 + i0);
                v1 = 1'b1; a1 = 5'(9 + i1); d1 = 32'h200 | 32'(9 + i1);
                @(negedge clk);
                chk("cont_rdy0", {31'd0, rdy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
                chk("cont_rdy1", {31'd0, rdy1}, (i % 2 == 1) ? 32'd1 : 32'd0);
                push(ct_addr[i], ct_data[i]);
                if (i % 2 == 0) i0++; else i1++;
                next_cycle();
            end
            v0 = 1'b0; v1 = 1'b0;
        end

        // Zero register: accepted but no strobe; pointer still advances
        v1 = 1'b1; a1 = 5'd0; d1 = 32'h1234;
        @(negedge clk);
        chk("zero_rdy1", {31'd0, rdy1}, 32'd1);
        next_cycle();
        v1 = 1'b0;
        @(negedge clk);
        chk("zero_no_wr", {31'd0, wr_en}, 32'd0);
        next_cycle();
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h33;
        v1 = 1'b1; a1 = 5'd4; d1 = 32'h44;
        @(negedge clk);
        chk("zero_after_rdy0", {31'd0, rdy0}, 32'd1);
        chk("zero_after_rdy1", {31'd0, rdy1}, 32'd0);
        push(5'd3, 32'h33);
        next_cycle();
        v0 = 1'b0;
        @(negedge clk);
        chk("zero_after2_rdy1", {31'd0, rdy1}, 32'd1);
        push(5'd4, 32'h44);
        next_cycle();
        v1 = 1'b0;

        // Clear sweep with a competing request in the same cycle
        clr = 1'b1;
        v0 = 1'b1; a0 = 5'd6; d0 = 32'h66;
        @(negedge clk);
        chk("clr_rdy0", {31'd0, rdy0}, 32'd0);
        chk("clr_rdy1", {31'd0, rdy1}, 32'd0);
        for (int i = 0; i < 32; i++) push(5'(i), 32'd0);
        next_cycle();
        clr = 1'b0;
        begin
            int busy_cnt = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                if (busy) busy_cnt++;
                chk("sweep_rdy0", {31'd0, rdy0}, 32'd0);
                next_cycle();
            end
            chk("sweep_busy_cycles", busy_cnt, 32'd32);
        end
        @(negedge clk);
        chk("sweep_done_busy", {31'd0, busy}, 32'd0);
        chk("sweep_done_rdy0", {31'd0, rdy0}, 32'd1);
        push(5'd6, 32'h66);
        next_cycle();
        v0 = 1'b0;
        repeat (2) next_cycle();

        // Clear held 40 cycles: back-to-back sweeps; a pulse mid-sweep is ignored
        for (int i = 0; i < 64; i++) push(5'(i % 32), 32'd0);
        for (int k = 0; k < 70; k++) begin
            clr = (k < 40) || (k == 45);
            @(negedge clk);
            chk("overlap_busy", {31'd0, busy},
                ((k >= 1 && k <= 32) || (k >= 34 && k <= 65)) ? 32'd1 : 32'd0);
            next_cycle();
        end
        clr = 1'b0;
        repeat (2) next_cycle();

        // Reset during the sweep write of address 17
        for (int i = 0; i < 18; i++) push(5'(i), 32'd0);
        for (int k = 0; k < 20; k++) begin
            clr = (k == 0);
            @(negedge clk);
            if (k == 19) begin
                chk("pre_rst_addr", {27'd0, wr_addr}, 32'd17);
                #2;
                rstn = 1'b0;
                #1;
                chk("midrst_wr_en", {31'd0, wr_en}, 32'd0);
                chk("midrst_busy", {31'd0, busy}, 32'd0);
                chk("midrst_addr", {27'd0, wr_addr}, 32'd0);
            end
            next_cycle();
        end
        clr = 1'b0;
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        v1 = 1'b1; a1 = 5'd8; d1 = 32'h88;
        @(negedge clk);
        chk("post_rst_rdy1", {31'd0, rdy1}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        push(5'd8, 32'h88);
        next_cycle();
        v1 = 1'b0;
        repeat (3) next_cycle();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Owns the single write port of the 2-read/1-write register file.
- Shares that port between two writeback requesters (e.g. ALU and load unit) using valid/ready handshakes and round-robin arbitration.
- Drops writes to register 0 when configured.
- On command, runs a clear sequencer that sweeps every entry to zero.
- Sits between the pipeline writeback stage and the register file write inputs.

Parameters:
- BW_DATA, 32, register data width.
- BW_ADDR, 5, register address width; depth = 2**BW_ADDR.
- ZERO_REG, 1, when 1, accepted writes to address 0 are discarded (no write strobe).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_clr  input  1  clear request, level-sampled in IDLE.
- o_busy  output  1  high while the clear sweep is in progress.
- i_req0_valid  input  1  requester 0 write valid.
- o_req0_ready  output  1  requester 0 grant/ready.
- i_req0_addr  input  BW_ADDR  requester 0 destination register.
- i_req0_data  input  BW_DATA  requester 0 write data.
- i_req1_valid  input  1  requester 1 write valid.
- o_req1_ready  output  1  requester 1 grant/ready.
- i_req1_addr  input  BW_ADDR  requester 1 destination register.
- i_req1_data  input  BW_DATA  requester 1 write data.
- o_rf_wr_en  output  1  register file write enable.
- o_rf_wr_addr  output  BW_ADDR  register file write address.
- o_rf_wr_data  output  BW_DATA  register file write data.

Behaviour:
- Interface: one clock (i_clk); reset i_rstn is asynchronous, active-low.
- Reset:
  - state=IDLE, rr pointer=0 (requester 0 has priority).
  - o_rf_wr_en=0, o_rf_wr_addr=0, o_rf_wr_data=0, o_busy=0.
  - Sweep counter=0.
  - Reset asserted mid-sweep aborts the sweep immediately; no resume.
- States: IDLE, CLEAR.
- Readiness (combinational; depends on pointer, state, i_clr and the other requester's valid only, never on the requester's own valid):
  - o_reqN_ready = (state==IDLE) && !i_clr && (ptr==N || !i_req(1-N)_valid).
  - Both readys are low in CLEAR.
- Handshake: a transfer occurs on the edge where valid && ready. Requesters hold addr/data stable while valid and not ready.
- Round-robin:
  - If both valid, the pointer's requester is granted.
  - After any transfer, ptr <= the other requester.
  - The pointer is unchanged on cycles with no transfer.
- Write output is registered, 1-cycle latency. On a transfer edge:
  - o_rf_wr_addr/o_rf_wr_data <= granted addr/data.
  - o_rf_wr_en <= 1, except 0 when ZERO_REG==1 and addr==0. The transfer still completes and the pointer still advances.
  - On non-transfer edges in IDLE: o_rf_wr_en <= 0, addr/data hold.
- Clear entry: i_clr high on an edge in IDLE gives state<=CLEAR, cnt<=0, o_busy<=1.
  - i_clr beats any pending valid in the same cycle; readys are low that cycle.
- CLEAR, each edge:
  - o_rf_wr_en<=1, o_rf_wr_addr<=cnt, o_rf_wr_data<=0, cnt<=cnt+1.
  - On the edge where cnt==2**BW_ADDR-1: state<=IDLE, o_busy<=0, cnt wraps to 0.
  - Result: exactly 2**BW_ADDR consecutive write strobes, addresses 0..2**BW_ADDR-1 ascending.
  - Address 0 is written with zero even when ZERO_REG==1.
- i_clr in CLEAR is ignored (no restart, no extension).
- i_clr still high on the first IDLE edge after the sweep starts a new sweep.
- Pointer is unchanged by a sweep.
- Throughput: one write per cycle sustained in IDLE; with both requesters continuously valid, grants alternate 0,1,0,1…

Test Plan:
- Reset then single write: req0 valid addr=5 data=0xDEADBEEF → ready0=1 same cycle; next cycle o_rf_wr_en=1, addr=5, data=0xDEADBEEF; following cycle wr_en=0.
- Contention: both valid continuously for 4 cycles (req0 addr 1..4, req1 addr 9..12) starting ptr=0 → write addresses 1,9,2,10 on consecutive cycles; each requester stalls every other cycle with addr/data held.
- Zero register: ZERO_REG=1, req1 writes addr=0 data=0x1234 → ready1=1, o_rf_wr_en stays 0; next simultaneous request grants req0 (pointer advanced).
- Clear sweep: i_clr pulse 1 cycle with req0 valid same cycle → ready0=0; 32 consecutive wr_en cycles, addr 0..31, data 0; o_busy high exactly 32 cycles; req0 then granted on the first IDLE cycle.
- Clear overlap: i_clr held high 40 cycles → first sweep of 32, then a second sweep starts immediately; i_clr pulses during a sweep do not lengthen it.
- Reset mid-sweep: i_rstn low at sweep address 17 → wr_en, busy, addr drop to 0 immediately; after release, state IDLE, req1-only request granted and written normally.
